uart_code_lock: RTL and testbench

Parametrised UART-driven code lock for the user project area: receives 8N1 serial characters on a Caravel GPIO, compares each complete entry against a CODE_LEN-byte code, and drives the green/red status LEDs. It generalises the single-code lock to a configurable code length, baud divisor, open duration, entry timeout and failed-attempt lockout. The bench drives `uart` on mprj_io[8] and observes `led_green` on mprj_io[9] and `led_red` on mprj_io[10]; the lock is open while `led_green` is low.

---
 rtl/uart_code_lock_pkg.sv | 23 ++
 rtl/uart_code_lock_if.sv | 33 +++
 rtl/uart_rx.sv | 113 +++++++++++
 rtl/uart_code_lock.sv | 194 +++++++++++++++++++
 tb/tb_uart_code_lock.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_code_lock_pkg.sv
// code_lock_pkg: definitions shared by the UART code lock.
//   - FSM state encoding of the lock controller
//   - 8N1 frame constants used by the receiver
//   - cnt_width(): width of a counter that has to reach (largest cycle count - 1)
package code_lock_pkg;

   localparam logic [1:0] ST_LOCKED  = 2'd0;
   localparam logic [1:0] ST_ENTRY   = 2'd1;
   localparam logic [1:0] ST_OPEN    = 2'd2;
   localparam logic [1:0] ST_LOCKOUT = 2'd3;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/uart_code_lock_if.sv
// uart_code_lock_if: serial input, code and status outputs of the code lock.
//   uart          serial line, idle high
//   code          expected code, byte 0 in [7:0] is entered first
//   led_green     high = locked, low = open
//   led_red       high = lockout
//   attempt_done  one-cycle pulse when an entry is judged
//   attempt_ok    valid with attempt_done, 1 = correct code
//   fail_count    consecutive failed entries
// master: drives uart/code (environment); slave: the lock.
interface uart_code_lock_if #(
   parameter int CODE_LEN  = 4,
   parameter int MAX_FAILS = 3
);
   localparam int FC_W = $clog2(MAX_FAILS + 1);

   logic                    uart;
   logic [8*CODE_LEN-1:0]   code;
   logic                    led_green;
   logic                    led_red;
   logic                    attempt_done;
   logic                    attempt_ok;
   logic [FC_W-1:0]         fail_count;

   modport master (
      output uart, code,
      input  led_green, led_red, attempt_done, attempt_ok, fail_count
   );

   modport slave (
      input  uart, code,
      output led_green, led_red, attempt_done, attempt_ok, fail_count
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
//   clk       system clock
//   rstb      synchronous active-low reset
//   rx        asynchronous serial input, idle high
//   rx_data   received byte, valid while rx_valid is high
//   rx_valid  one-cycle pulse, stop bit sampled high
//   rx_ferr   one-cycle pulse, stop bit sampled low (no data)
// The start bit is re-checked half a bit after the falling edge; a high
// level there is treated as a glitch and the frame is dropped.
module uart_rx
   import code_lock_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_ferr
);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV/2 - 1);
   localparam logic [DIV_W-1:0] FULL = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] LAST = BIT_W'(DATA_BITS - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   logic [1:0]           sync_q;
   logic                 prev_q;
   logic [1:0]           st_q, st_d;
   logic [DIV_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_s;

   assign rx_s = sync_q[1];

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (st_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (prev_q && !rx_s) st_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF) begin
               cnt_d = '0;
               st_d  = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};   // LSB arrives first
               if (bit_q == LAST) st_d = RX_STOP;
               else               bit_d = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin   // RX_STOP; rearm right at the stop sample
            if (cnt_q == FULL) begin
               valid_d = rx_s;
               ferr_d  = !rx_s;
               st_d    = RX_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         st_q    <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx};
         prev_q  <= rx_s;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_data  = shift_q;
   assign rx_valid = valid_q;
   assign rx_ferr  = ferr_q;
endmodule

// File: rtl/uart_code_lock.sv
// uart_code_lock: UART-driven code lock.
//   clk   system clock
//   rstb  synchronous active-low reset
//   bus   uart_code_lock_if.slave (uart, code in; LEDs, attempt status out)
// Every entry consumes CODE_LEN bytes before it is judged. A correct entry
// opens the lock (led_green low) for OPEN_CYCLES clocks. An entry idle for
// TIMEOUT_CYCLES clocks or hit by a framing error is abandoned unjudged.
// Macro LOCKOUT_EN: when defined, MAX_FAILS consecutive failures lock the
// input out for LOCKOUT_CYCLES clocks (led_red high); when undefined,
// fail_count and led_red are tied low.
module uart_code_lock
   import code_lock_pkg::*;
#(
   parameter int CLK_DIV        = 16,
   parameter int CODE_LEN       = 4,
   parameter int OPEN_CYCLES    = 100,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 200
) (
   input  logic          clk,
   input  logic          rstb,
   uart_code_lock_if.slave bus
);
   localparam int FC_W  = $clog2(MAX_FAILS + 1);
   localparam int CNT_W = cnt_width(OPEN_CYCLES, TIMEOUT_CYCLES, LOCKOUT_CYCLES);
   localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ferr;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             mism_q, mism_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             done_q, done_d;
   logic             ok_q, ok_d;
   logic             green_q, green_d;
   logic [7:0]       code_byte;
   logic             judge, judge_bad;
`ifdef LOCKOUT_EN
   logic [FC_W-1:0]  fail_q, fail_d, fail_inc;
   logic             red_q, red_d;
`endif

   uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
      .clk      (clk),
      .rstb     (rstb),
      .rx       (bus.uart),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr)
   );

   // code is read live, so only bytes not yet compared see a change
   always_comb code_byte = bus.code[8*int'(idx_q) +: 8];

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mism_d    = mism_q;
      timer_d   = timer_q;
      done_d    = 1'b0;
      ok_d      = 1'b0;
      judge     = 1'b0;
      judge_bad = 1'b0;
`ifdef LOCKOUT_EN
      fail_d    = fail_q;
      fail_inc  = (fail_q == FC_W'(MAX_FAILS)) ? fail_q : fail_q + 1'b1;
`endif
      case (state_q)
         ST_LOCKED: begin
            idx_d   = '0;
            mism_d  = 1'b0;
            timer_d = '0;
            if (rx_valid) begin
               if (CODE_LEN == 1) begin
                  judge     = 1'b1;
                  judge_bad = (rx_data != bus.code[7:0]);
               end else begin
                  state_d = ST_ENTRY;
                  idx_d   = IDX_W'(1);
                  mism_d  = (rx_data != bus.code[7:0]);
               end
            end
         end
         ST_ENTRY: begin
            // a byte in the expiry cycle wins over the timeout
            if (rx_valid) begin
               timer_d = '0;
               if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                  judge     = 1'b1;
                  judge_bad = mism_q | (rx_data != code_byte);
               end else begin
                  idx_d  = idx_q + 1'b1;
                  mism_d = mism_q | (rx_data != code_byte);
               end
            end else if (rx_ferr || timer_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_LOCKED;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_OPEN: begin
            if (timer_q == CNT_W'(OPEN_CYCLES - 1)) begin
               state_d = ST_LOCKED;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin   // ST_LOCKOUT
`ifdef LOCKOUT_EN
            if (timer_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
               state_d = ST_LOCKED;
               timer_d = '0;
               fail_d  = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
`else
            state_d = ST_LOCKED;
`endif
         end
      endcase

      if (judge) begin
         done_d  = 1'b1;
         ok_d    = !judge_bad;
         idx_d   = '0;
         mism_d  = 1'b0;
         timer_d = '0;
         if (!judge_bad) begin
            state_d = ST_OPEN;
`ifdef LOCKOUT_EN
            fail_d  = '0;
`endif
         end else begin
`ifdef LOCKOUT_EN
            fail_d  = fail_inc;
            state_d = (fail_inc == FC_W'(MAX_FAILS)) ? ST_LOCKOUT : ST_LOCKED;
`else
            state_d = ST_LOCKED;
`endif
         end
      end

      // LEDs follow the next state so they change together with it
      green_d = (state_d != ST_OPEN);
`ifdef LOCKOUT_EN
      red_d   = (state_d == ST_LOCKOUT);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= ST_LOCKED;
         idx_q   <= '0;
         mism_q  <= 1'b0;
         timer_q <= '0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         green_q <= 1'b1;
`ifdef LOCKOUT_EN
         fail_q  <= '0;
         red_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mism_q  <= mism_d;
         timer_q <= timer_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         green_q <= green_d;
`ifdef LOCKOUT_EN
         fail_q  <= fail_d;
         red_q   <= red_d;
`endif
      end
   end

   assign bus.led_green    = green_q;
   assign bus.attempt_done = done_q;
   assign bus.attempt_ok   = ok_q;
`ifdef LOCKOUT_EN
   assign bus.led_red      = red_q;
   assign bus.fail_count   = fail_q;
`else
   assign bus.led_red      = 1'b0;
   assign bus.fail_count   = FC_W'(0);
`endif
endmodule

// File: tb/tb_uart_code_lock.sv
// tb_uart_code_lock: directed bench for uart_code_lock (CLK_DIV=16,
// code "1234", OPEN 100, TIMEOUT 1000, MAX_FAILS 3, LOCKOUT 200).
// Expectations follow the LOCKOUT_EN setting of the build.
module tb_uart_code_lock;
   localparam int CLK_DIV = 16;
`ifdef LOCKOUT_EN
   localparam int LK = 1;
`else
   localparam int LK = 0;
`endif

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   uart_code_lock_if #(.CODE_LEN(4), .MAX_FAILS(3)) bus ();

   uart_code_lock #(
      .CLK_DIV(CLK_DIV), .CODE_LEN(4), .OPEN_CYCLES(100),
      .TIMEOUT_CYCLES(1000), .MAX_FAILS(3), .LOCKOUT_CYCLES(200)
   ) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // cycle-stamped observation of pulses and LED edges
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int done_cnt = 0, done_cyc = 0, rxv_cnt = 0, rxv_cyc = 0, ferr_cnt = 0;
   int green_start = 0, green_len = 0, green_falls = 0, red_start = 0, red_len = 0;
   logic last_ok = 1'b0;
   logic prev_green = 1'b1, prev_red = 1'b0;

   always @(negedge clk) begin
      if (dut.rx_valid) begin rxv_cnt++; rxv_cyc = cyc; end
      if (dut.rx_ferr) ferr_cnt++;
      if (bus.attempt_done) begin done_cnt++; done_cyc = cyc; last_ok = bus.attempt_ok; end
      if (prev_green && !bus.led_green) begin green_start = cyc; green_falls++; end
      if (!prev_green && bus.led_green) green_len = cyc - green_start;
      if (!prev_red && bus.led_red) red_start = cyc;
      if (prev_red && !bus.led_red) red_len = cyc - red_start;
      prev_green = bus.led_green;
      prev_red   = bus.led_red;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk) bus.uart = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.uart = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      bus.uart = stop;
      repeat (CLK_DIV) @(negedge clk);
      bus.uart = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic expect_attempt(input string tag, input int d0, input logic ok);
      chk({tag, "_done"}, done_cnt - d0, 1);
      chk({tag, "_ok"}, last_ok, ok);
   endtask

   int d0, r0, f0, gf0;

   initial begin
      bus.uart = 1'b1;
      bus.code = 32'h34333231;
      rstb     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_green", bus.led_green, 1);
      chk("rst_red", bus.led_red, 0);
      chk("rst_done", bus.attempt_done, 0);
      chk("rst_ok", bus.attempt_ok, 0);
      chk("rst_fc", bus.fail_count, 0);
      rstb = 1'b1;
      repeat (5) @(negedge clk);

      // correct code opens for exactly 100 clocks
      d0 = done_cnt;
      send_str("1234");
      expect_attempt("t1", d0, 1'b1);
      chk("t1_latency", done_cyc - rxv_cyc, 1);
      chk("t1_green_edge", green_start - done_cyc, 0);
      chk("t1_green_low", bus.led_green, 0);
      repeat (110) @(negedge clk);
      chk("t1_open_len", green_len, 100);
      chk("t1_green_back", bus.led_green, 1);

      // two wrong entries, then success clears the count
      for (int k = 1; k <= 2; k++) begin
         d0 = done_cnt;
         send_str("1235");
         expect_attempt("t2_bad", d0, 1'b0);
         chk("t2_fc", bus.fail_count, LK * k);
         chk("t2_red", bus.led_red, 0);
      end
      d0 = done_cnt;
      send_str("1234");
      expect_attempt("t2_good", d0, 1'b1);
      chk("t2_fc_clr", bus.fail_count, 0);
      repeat (110) @(negedge clk);

      // three wrong entries
      for (int k = 1; k <= 3; k++) begin
         d0 = done_cnt;
         send_str("9999");
         expect_attempt("t3_bad", d0, 1'b0);
         chk("t3_fc", bus.fail_count, LK * k);
      end
      chk("t3_red", bus.led_red, LK);
`ifdef LOCKOUT_EN
      d0  = done_cnt;
      gf0 = green_falls;
      send_byte("1", 1'b1);
      chk("t3_in_lockout", bus.led_red, 1);
      repeat (120) @(negedge clk);
      chk("t3_ignored", done_cnt - d0, 0);
      chk("t3_no_open", green_falls - gf0, 0);
      chk("t3_red_len", red_len, 200);
`else
      repeat (10) @(negedge clk);
`endif
      chk("t3_fc_after", bus.fail_count, 0);
      chk("t3_red_after", bus.led_red, 0);
      d0 = done_cnt;
      send_str("1234");
      expect_attempt("t3_open", d0, 1'b1);
      repeat (110) @(negedge clk);

      // inter-byte timeout abandons "12"; "34"+"12" is then judged wrong
      d0 = done_cnt;
      send_str("12");
      repeat (1001) @(negedge clk);
      send_str("34");
      chk("t4_no_judge", done_cnt - d0, 0);
      send_str("12");
      expect_attempt("t4_3412", d0, 1'b0);
      chk("t4_fc", bus.fail_count, LK);
      d0 = done_cnt;
      send_str("1234");
      expect_attempt("t4_open", d0, 1'b1);
      repeat (110) @(negedge clk);

      // framing error aborts the entry
      f0 = ferr_cnt;
      d0 = done_cnt;
      send_byte("1", 1'b0);
      chk("t5_ferr", ferr_cnt - f0, 1);
      chk("t5_no_judge", done_cnt - d0, 0);
      send_str("1234");
      expect_attempt("t5_open", d0, 1'b1);
      repeat (110) @(negedge clk);

      // glitch, then reset in the middle of a frame and of an entry
      d0 = done_cnt;
      send_str("1235");
      expect_attempt("t6_bad", d0, 1'b0);
      send_str("12");
      r0 = rxv_cnt;
      @(negedge clk) bus.uart = 1'b0;
      repeat (4) @(negedge clk);
      bus.uart = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_glitch", rxv_cnt - r0, 0);
      bus.uart = 1'b0;
      repeat (40) @(negedge clk);
      rstb = 1'b0;
      @(negedge clk);
      rstb     = 1'b1;
      bus.uart = 1'b1;
      chk("t6_rst_green", bus.led_green, 1);
      chk("t6_rst_red", bus.led_red, 0);
      chk("t6_rst_done", bus.attempt_done, 0);
      chk("t6_rst_ok", bus.attempt_ok, 0);
      chk("t6_rst_fc", bus.fail_count, 0);
      repeat (200) @(negedge clk);
      chk("t6_no_rxv", rxv_cnt - r0, 0);
      d0 = done_cnt;
      send_str("1234");
      expect_attempt("t6_open", d0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
